accident_alarm: RTL and testbench



---
 rtl/accident_alarm_pkg.sv | 12 +
 rtl/alarm_debounce.sv | 60 ++++++
 rtl/accident_alarm.sv | 50 +++++
 tb/tb_accident_alarm.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/accident_alarm_pkg.sv
// Shared widths and helpers for the accident alarm block.
package accident_alarm_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned POP_W = 3;

  // Number of set bits in a 4-bit sensor vector; 3 bits hold 0..4 without overflow.
  function automatic logic [POP_W-1:0] popcount4(input logic [3:0] v);
    popcount4 = POP_W'(v[0]) + POP_W'(v[1]) + POP_W'(v[2]) + POP_W'(v[3]);
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Persistence filter for the alarm condition: saturating counter, alarm set/clear, trip pulse.
module alarm_debounce
  import accident_alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned LATCH           = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cond,
  input  logic ack,
  output logic o,
  output logic trip
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             o_q, o_d;
  logic             trip_q, trip_d;

  // Counter saturates at DEB; alarm set on the edge the counter reaches DEB, set beats ack.
  always_comb begin
    cnt_d  = cnt_q;
    o_d    = o_q;
    trip_d = 1'b0;

    if (cond) begin
      if (cnt_q != DEB) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (LATCH != 0) begin
      if (cond && (cnt_q == DEB - CNT_W'(1))) o_d = 1'b1;
      else if (ack && !cond)                  o_d = 1'b0;
    end else begin
      o_d = (cnt_d == DEB);
    end

    trip_d = o_d & ~o_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      o_q    <= 1'b0;
      trip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      o_q    <= o_d;
      trip_q <= trip_d;
    end
  end

  assign o    = o_q;
  assign trip = trip_q;

endmodule

// File: rtl/accident_alarm.sv
// Accident alarm top: samples four crash sensors, counts active ones, debounces the threshold test.
module accident_alarm
  import accident_alarm_pkg::*;
#(
  parameter int unsigned THRESHOLD       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned LATCH           = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             ack,
  output logic             o,
  output logic             trip,
  output logic [POP_W-1:0] count
);

  logic [3:0] s_q, s_d;
  logic       cond_c;

  // Next sample is the raw sensor vector (s_q[3] = a ... s_q[0] = d).
  always_comb begin
    s_d = {a, b, c, d};
  end

  // Sensor sample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign count  = popcount4(s_q);
  assign cond_c = (count >= POP_W'(THRESHOLD));

  alarm_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LATCH           (LATCH)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .cond  (cond_c),
    .ack   (ack),
    .o     (o),
    .trip  (trip)
  );

endmodule

// File: tb/tb_accident_alarm.sv
// Scoreboard bench for accident_alarm: latched (default) and non-latched builds driven in parallel.
module tb_accident_alarm;

  localparam int TH  = 2;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, ack = 1'b0;
  logic       o, trip, o0, trip0;
  logic [2:0] count, count0;

  always #5 clk = ~clk;

  accident_alarm dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .ack(ack),
    .o(o), .trip(trip), .count(count)
  );

  accident_alarm #(.THRESHOLD(2), .DEBOUNCE_CYCLES(3), .LATCH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .ack(ack),
    .o(o0), .trip(trip0), .count(count0)
  );

  typedef struct {
    logic       o;
    logic       trip;
    logic [2:0] cnt;
    logic       o0;
    logic       trip0;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sweep_on = 0;
  int   sweep_trips = 0;
  int   sweep_trips0 = 0;

  // Reference model state: last sampled vector, uncapped run of condition-true samples, alarm levels.
  logic [3:0] m_samp = '0;
  int         m_run = 0;
  logic       m_o = 1'b0, m_o0 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v, input string tag);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s [%s] cycle %0d: got %0d expected %0d", nm, tag, cyc, act, exp_v);
    end
  endtask

  // Drive one cycle of stimulus and push the model's post-edge expectation.
  task automatic step(input logic [3:0] v, input logic ak, input logic rn, input string tag);
    exp_t e;
    logic cp, n_o, n_o0;
    @(negedge clk);
    {a, b, c, d} = v;
    ack = ak;
    rst_n = rn;
    if (!rn) begin
      m_samp = '0; m_run = 0;
      e.trip = 1'b0; e.trip0 = 1'b0;
      m_o = 1'b0; m_o0 = 1'b0;
    end else begin
      cp    = ($countones(m_samp) >= TH);
      m_run = cp ? m_run + 1 : 0;
      n_o   = m_o;
      if (m_run == DEB)     n_o = 1'b1;
      else if (ak && !cp)   n_o = 1'b0;
      n_o0    = (m_run >= DEB);
      e.trip  = n_o & ~m_o;
      e.trip0 = n_o0 & ~m_o0;
      m_o     = n_o;
      m_o0    = n_o0;
      m_samp  = v;
    end
    e.o   = m_o;
    e.o0  = m_o0;
    e.cnt = 3'($countones(m_samp));
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: after every active edge, pop one expectation and compare both builds.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("o",      int'(o),      int'(e.o),     e.tag);
        chk("trip",   int'(trip),   int'(e.trip),  e.tag);
        chk("count",  int'(count),  int'(e.cnt),   e.tag);
        chk("o_nl",   int'(o0),     int'(e.o0),    e.tag);
        chk("trip_nl",int'(trip0),  int'(e.trip0), e.tag);
        chk("cnt_nl", int'(count0), int'(e.cnt),   e.tag);
        if (sweep_on) begin
          if (trip  === 1'b1) sweep_trips++;
          if (trip0 === 1'b1) sweep_trips0++;
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    int hold;
    logic ak, rn;

    // Reset held with all sensors active, then release.
    repeat (3) step(4'b1111, 1'b0, 1'b0, "reset");
    step(4'b1111, 1'b0, 1'b1, "release");
    step(4'b0000, 1'b1, 1'b0, "reset2");
    step(4'b0000, 1'b0, 1'b1, "idle");

    // Exhaustive code sweep: hold 8 cycles, then clear with ack.
    sweep_on = 1;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      repeat (8) step(v, 1'b0, 1'b1, "sweep");
      repeat (2) step(4'b0000, 1'b1, 1'b1, "sweep_clr");
    end
    @(posedge clk); #2;
    sweep_on = 0;
    chk("sweep_trip_codes",    sweep_trips,  11, "sweep");
    chk("sweep_trip_codes_nl", sweep_trips0, 11, "sweep");

    // Glitch shorter than the debounce window.
    repeat (2) step(4'b1100, 1'b0, 1'b1, "glitch");
    repeat (4) step(4'b0000, 1'b0, 1'b1, "glitch_off");

    // Latch and acknowledge behaviour.
    repeat (6) step(4'b1010, 1'b0, 1'b1, "latch_set");
    repeat (3) step(4'b0000, 1'b0, 1'b1, "latch_hold");
    repeat (5) step(4'b1010, 1'b1, 1'b1, "ack_ignored");
    step(4'b0000, 1'b1, 1'b1, "ack_sample");
    step(4'b0000, 1'b1, 1'b1, "ack_clear");
    step(4'b0000, 1'b0, 1'b1, "ack_idle");

    // Set coincides with ack: set wins.
    repeat (3) step(4'b0110, 1'b1, 1'b1, "set_vs_ack");
    repeat (3) step(4'b0110, 1'b1, 1'b1, "set_vs_ack_hold");
    repeat (2) step(4'b0000, 1'b1, 1'b1, "set_vs_ack_clr");

    // Mid-alarm reset and re-assertion.
    repeat (6) step(4'b1111, 1'b0, 1'b1, "pre_reset");
    step(4'b1111, 1'b0, 1'b0, "mid_reset");
    repeat (7) step(4'b1111, 1'b0, 1'b1, "post_reset");
    repeat (2) step(4'b0000, 1'b1, 1'b1, "post_reset_clr");

    // Non-latched build window: held 6 cycles then released.
    repeat (6) step(4'b0110, 1'b0, 1'b1, "nl_hold");
    repeat (3) step(4'b0000, 1'b0, 1'b1, "nl_drop");

    // Randomized stimulus with held sensor patterns.
    for (int n = 0; n < 120; n++) begin
      v = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        ak = ($urandom_range(0, 3) == 0);
        rn = ($urandom_range(0, 59) != 0);
        step(v, ak, rn, "random");
      end
    end

    @(posedge clk); #3;
    chk("queue_drained", q.size(), 0, "end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
